// File: rtl/sub4_serial.sv
// Bit-serial WIDTH-bit subtractor (d = a - b, borrow out) with start/done handshake.
// One difference bit is produced per clock, LSB first; a result takes WIDTH RUN cycles.
// Optional zero flag output z_o is built when SUB4_SERIAL_ZERO_FLAG_EN is defined.
module sub4_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             n_reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
  ,
  output logic             z_o
`endif
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             diff_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_shift;

`ifdef SUB4_SERIAL_ZERO_FLAG_EN
  // OR of all difference bits seen so far; z is its complement at the end.
  logic zacc_q, zacc_d;
  logic z_q, z_d;
`endif

  // One full-subtractor step on the current LSBs.
  always_comb begin
    diff_bit   = ra_q[0] ^ rb_q[0] ^ borrow_q;
    borrow_nxt = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & borrow_q);
    res_shift  = {diff_bit, res_q[WIDTH-1:1]};
  end

  // Next-state: FSM transitions, operand shifting and result capture.
  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bo_d     = bo_q;
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
    zacc_d   = zacc_q;
    z_d      = z_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts start exactly like IDLE so operations can run back to back.
        if (start_i) begin
          ra_d     = a_i;
          rb_d     = b_i;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
          zacc_d   = 1'b0;
`endif
          state_d  = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        ra_d     = {1'b0, ra_q[WIDTH-1:1]};
        rb_d     = {1'b0, rb_q[WIDTH-1:1]};
        res_d    = res_shift;
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CntW'(1);
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
        zacc_d   = zacc_q | diff_bit;
`endif
        if (cnt_q == CntLast) begin
          d_d     = res_shift;
          bo_d    = borrow_nxt;
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
          z_d     = ~(zacc_q | diff_bit);
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q  <= StIdle;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
    end
  end

`ifdef SUB4_SERIAL_ZERO_FLAG_EN
  // Zero-flag accumulator and held flag.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      zacc_q <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      z_q    <= z_d;
    end
  end

  assign z_o = z_q;
`endif

  // Status decoded from state so reset clears busy/done immediately.
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
    d_o    = d_q;
    bo_o   = bo_q;
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Self-checking bench for sub4_serial (WIDTH=4) against an arithmetic reference model.
// Build with SUB4_SERIAL_ZERO_FLAG_EN defined to also check the zero flag.
module tb_sub4_serial;

  localparam int unsigned W = 4;

  logic         clk;
  logic         n_reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
  logic         z;
`endif

  int total;
  int bad;

  sub4_serial #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .n_reset_i(n_reset),
    .start_i  (start),
    .a_i      (a_in),
    .b_i      (b_in),
    .d_o      (d),
    .bo_o     (bo),
    .busy_o   (busy),
    .done_o   (done)
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
    ,
    .z_o      (z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: difference modulo 2^W and unsigned borrow.
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic ref_bo(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  task automatic test_reset();
    n_reset = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    #12;
    total++;
    if ({d, bo, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got d=%b bo=%b busy=%b done=%b want all 0", d, bo, busy, done);
    end
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL reset_z: got %b want 0", z);
    end
`endif
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  // One full operation with latency, busy width, pulse width and result checks.
  task automatic test_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int cyc;
    int busy_cnt;
    logic [W-1:0] ed;
    logic         eb;
    ed = ref_d(x, y);
    eb = ref_bo(x, y);
    @(negedge clk);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 12) begin
      if (busy) busy_cnt++;
      cyc++;
      @(negedge clk);
    end
    total++;
    if (!done || cyc != W) begin
      bad++;
      $display("FAIL %s latency: got done=%b after %0d cycles want done=1 after %0d", tag, done,
               cyc, W);
    end
    total++;
    if (busy_cnt != W || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: got %0d busy cycles busy_at_done=%b want %0d and 0", tag,
               busy_cnt, busy, W);
    end
    total++;
    if (d !== ed || bo !== eb) begin
      bad++;
      $display("FAIL %s result: got d=%b bo=%b want d=%b bo=%b", tag, d, bo, ed, eb);
    end
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
    total++;
    if (z !== (ed == '0)) begin
      bad++;
      $display("FAIL %s z: got %b want %b", tag, z, ed == '0);
    end
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || d !== ed || bo !== eb) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b d=%b bo=%b want 0 0 %b %b", tag, done,
               busy, d, bo, ed, eb);
    end
  endtask

  task automatic test_directed();
    test_op(4'b0000, 4'b0000, "zero_zero");
    test_op(4'b0101, 4'b0011, "five_minus_three");
    test_op(4'b0000, 4'b0001, "zero_minus_one");
    test_op(4'b0001, 4'b0010, "one_minus_two");
    test_op(4'b1111, 4'b1111, "equal_max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_op(W'($urandom), W'($urandom), "random");
    end
  endtask

  // A start pulse during RUN must be ignored and operand changes must not matter.
  task automatic test_ignore_start();
    int ndone;
    logic [W-1:0] got_d;
    logic got_bo;
    ndone = 0;
    got_d = '0;
    got_bo = 1'b0;
    @(negedge clk);
    a_in  = 4'b1111;
    b_in  = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_in  = 4'b0000;
    b_in  = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    a_in  = 4'b0101;
    b_in  = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        got_d  = d;
        got_bo = bo;
      end
      @(negedge clk);
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL ignore_start count: got %0d done pulses want 1", ndone);
    end
    total++;
    if (got_d !== 4'b1110 || got_bo !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start result: got d=%b bo=%b want d=1110 bo=0", got_d, got_bo);
    end
  endtask

  // start held through DONE restarts immediately; results are one per W+1 cycles.
  task automatic test_back_to_back();
    int ndone;
    int t1;
    int t2;
    ndone = 0;
    t1 = -1;
    t2 = -1;
    @(negedge clk);
    a_in  = 4'b1000;
    b_in  = 4'b0001;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (done) begin
        if (ndone == 0) t1 = i;
        else if (ndone == 1) t2 = i;
        ndone++;
        total++;
        if (d !== 4'b0111 || bo !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b result: got d=%b bo=%b busy=%b want d=0111 bo=0 busy=0", d, bo,
                   busy);
        end
      end else if (ndone == 1 && start) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b restart: got busy=%b right after done want 1", busy);
        end
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (ndone != 2 || t2 - t1 != W + 1) begin
      bad++;
      $display("FAIL b2b spacing: got %0d dones gap %0d want 2 dones gap %0d", ndone, t2 - t1,
               W + 1);
    end
  endtask

  // Asynchronous reset in the middle of RUN aborts without a done pulse.
  task automatic test_mid_reset();
    int ndone;
    int nbusy;
    ndone = 0;
    nbusy = 0;
    @(negedge clk);
    a_in  = 4'b0011;
    b_in  = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    total++;
    if ({d, bo, busy, done} !== '0) begin
      bad++;
      $display("FAIL mid_reset outputs: got d=%b bo=%b busy=%b done=%b want all 0", d, bo, busy,
               done);
    end
`ifdef SUB4_SERIAL_ZERO_FLAG_EN
    total++;
    if (z !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset z: got %b want 0", z);
    end
`endif
    #2;
    n_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    total++;
    if (ndone != 0 || nbusy != 0 || d !== '0) begin
      bad++;
      $display("FAIL mid_reset aftermath: got %0d dones %0d busy d=%b want 0 0 0000", ndone,
               nbusy, d);
    end
    test_op(4'b1010, 4'b0110, "after_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub4_serial.md
Name: sub4_serial

Overview:
- Bit-serial WIDTH-bit subtractor with start/done handshake. It computes d = a - b with a borrow-out and consumes one bit per clock, LSB first.
- It is the inverse-direction companion to the ripple adder in the TD4 ALU path.
- It is used where gate count matters more than latency, and as a cross-check of adder results (a + b - b == a).

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when not busy
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- d  output  WIDTH  difference a - b mod 2^WIDTH; valid when done=1, held until next accepted start
- bo  output  1  borrow out; 1 when a < b unsigned
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset is asynchronous on n_reset low. Effects:
  - d=0, bo=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter clear to 0.
  - FSM goes to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at a clock edge: latch a->ra, b->rb, borrow=0, counter=0, busy=1, goto RUN.
  - When start=0: stay in IDLE.
- RUN: each clock performs one bit step.
  - Difference bit: x = ra[0] ^ rb[0] ^ borrow.
  - Next borrow: (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow).
  - Shift ra and rb right by 1.
  - Shift x into the MSB of the result shift register.
  - Increment the counter.
- RUN -> DONE: on the step where counter == WIDTH-1. On that edge:
  - Copy the result register to d and the final borrow to bo.
  - busy=0, done=1.
- DONE: lasts exactly one cycle; done returns to 0 on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation): goto RUN and set busy=1.
  - Otherwise goto IDLE.
- Latency: start accepted at edge N; done=1 and d/bo valid after edge N+WIDTH. With WIDTH=4, done is high in the cycle following the 4th RUN edge.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. a and b may change freely during RUN with no effect.
- d and bo hold their last values outside DONE. They change only on the RUN->DONE edge or on reset.
- busy and done are never high simultaneously.
- Wrap-around:
  - 0 - 1 gives d=all ones, bo=1.
  - Equal operands give d=0, bo=0.
- Reset mid-RUN aborts the operation. There is no done pulse, and outputs go to reset values immediately.

Optional Feature:
- Macro: SUB4_SERIAL_ZERO_FLAG_EN.
- When defined:
  - Adds output port z (1 bit).
  - z is updated on the RUN->DONE edge: 1 when the final d == 0, else 0.
  - z holds with d and resets to 0.
  - z is computed serially as an OR-accumulator of the shifted difference bits. There is no WIDTH-wide comparator on d.
- When undefined: port z is absent and the accumulator logic is not built. All other behaviour is identical.

Test Plan:
- Reset, then a=0000 b=0000 start -> after 4 RUN edges: done pulse, d=0000, bo=0; with the flag enabled, z=1.
- a=0101 b=0011 start -> d=0010, bo=0. Check busy=1 for exactly 4 cycles and that done is a single-cycle pulse.
- a=0000 b=0001 -> d=1111, bo=1. Then a=0001 b=0010 -> d=1111, bo=1. Then a=1111 b=1111 -> d=0000, bo=0.
- Start with a=1111 b=0001. Two cycles later, pulse start with a=0000 b=0000 and change a/b mid-RUN -> d=1110, bo=0, exactly one done. The second start is ignored.
- Back-to-back: hold start=1 through DONE with a=1000 b=0001 -> d=0111, then an immediate second run. Verify the second done occurs 5 cycles after the first.
- Mid-RUN n_reset low for half a cycle asynchronously -> busy, done, d and bo go to 0 before the next clock edge. No done pulse follows. A new start afterwards works normally.
